// File: rtl/i2cm_defs.sv
// Shared I2C master definitions: bit-engine command encodings, byte sequencer
// state encodings and the phase-chain helpers used by i2cm_byte.
package i2cm_defs;

    localparam logic [4:0] CMD_NOP   = 5'b00000;
    localparam logic [4:0] CMD_START = 5'b00001;
    localparam logic [4:0] CMD_STOP  = 5'b00010;
    localparam logic [4:0] CMD_WRITE = 5'b00100;
    localparam logic [4:0] CMD_READ  = 5'b01000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Phase following 'cur' once it completes; empty phases are skipped.
    function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                              input logic       start,
                                              input logic       data,
                                              input logic       stop);
        logic [2:0] nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE:  nxt = start ? S_START : data ? S_DATA : stop ? S_STOP : S_DONE;
            S_START: nxt = data ? S_DATA : stop ? S_STOP : S_DONE;
            S_DATA:  nxt = S_ACK;
            S_ACK:   nxt = stop ? S_STOP : S_DONE;
            S_STOP:  nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    // Bit command presented while in phase 'st'; wr selects write vs read byte.
    function automatic logic [4:0] phase_cmd(input logic [2:0] st, input logic wr);
        logic [4:0] cmd;
        cmd = CMD_NOP;
        case (st)
            S_START: cmd = CMD_START;
            S_DATA:  cmd = wr ? CMD_WRITE : CMD_READ;
            S_ACK:   cmd = wr ? CMD_READ : CMD_WRITE;
            S_STOP:  cmd = CMD_STOP;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/i2cm_byte.sv
// Byte-level I2C master sequencer above i2cm_bit: START / byte / ACK / STOP.
// Optional macro I2CM_NACK_STOP_EN forces a STOP after a NACKed write byte.
module i2cm_byte
    import i2cm_defs::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_start,
    input  logic             req_stop,
    input  logic             req_write,
    input  logic             req_read,
    input  logic             req_ack,
    input  logic [NBITS-1:0] req_din,
    output logic             rsp_done,
    output logic [NBITS-1:0] rsp_dout,
    output logic             rsp_nack,
    output logic             rsp_err,
    output logic             busy,
    output logic [4:0]       bit_cmd,
    output logic             bit_tbit,
    input  logic             bit_rbit,
    input  logic             bit_done,
    input  logic             bit_error,
    output logic             bit_clr_n,
    output logic [2:0]       fsm_state
);

    localparam logic [2:0] CNT_LOAD = 3'(NBITS - 1);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [NBITS-1:0] shift;
    logic [2:0]       cnt;
    logic             r_start;
    logic             r_stop;
    logic             r_write;
    logic             r_data;
    logic             r_ack;
    logic             wr_sel;
    logic             tbit_next;
    logic             stop_after_ack;
    logic             advance;
    logic             active;

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign rsp_done  = (state == S_DONE);
    assign bit_clr_n = clr_n;
    assign fsm_state = state;
    assign active    = (state != S_IDLE) && (state != S_DONE);

`ifdef I2CM_NACK_STOP_EN
    assign stop_after_ack = r_stop | (r_write & bit_rbit);
`else
    assign stop_after_ack = r_stop;
`endif

    // In IDLE the request fields are not captured yet, so decide from the inputs.
    assign wr_sel  = (state == S_IDLE) ? req_write : r_write;
    assign advance = (state == S_IDLE) ? req_valid :
                     (state == S_DONE) ? 1'b1 : bit_done;

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = next_phase(S_IDLE, req_start, req_write | req_read, req_stop);
            S_DATA:  nxt = (cnt == 3'd0) ? S_ACK : S_DATA;
            S_ACK:   nxt = next_phase(S_ACK, 1'b0, 1'b0, stop_after_ack);
            default: nxt = next_phase(state, r_start, r_data, r_stop);
        endcase
    end

    // Transmit bit that accompanies the command registered for phase nxt.
    always_comb begin
        tbit_next = 1'b1;
        case (nxt)
            S_DATA: begin
                if (!wr_sel)
                    tbit_next = 1'b1;
                else if (state == S_DATA)
                    tbit_next = shift[NBITS-2];
                else if (state == S_IDLE)
                    tbit_next = req_din[NBITS-1];
                else
                    tbit_next = shift[NBITS-1];
            end
            S_ACK:   tbit_next = wr_sel ? 1'b1 : r_ack;
            default: tbit_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cmd  <= CMD_NOP;
            bit_tbit <= 1'b1;
            shift    <= '0;
            cnt      <= 3'd0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_write  <= 1'b0;
            r_data   <= 1'b0;
            r_ack    <= 1'b0;
            rsp_dout <= '0;
            rsp_nack <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (!clr_n) begin
            state    <= S_IDLE;
            bit_cmd  <= CMD_NOP;
            bit_tbit <= 1'b1;
            cnt      <= 3'd0;
        end else begin
            if (active && bit_error)
                rsp_err <= 1'b1;
            if (advance) begin
                state    <= nxt;
                bit_cmd  <= phase_cmd(nxt, wr_sel);
                bit_tbit <= tbit_next;
                case (state)
                    S_IDLE: begin
                        r_start <= req_start;
                        r_stop  <= req_stop;
                        r_write <= req_write;
                        r_data  <= req_write | req_read;
                        r_ack   <= req_ack;
                        shift   <= req_din;
                        cnt     <= CNT_LOAD;
                        rsp_err <= 1'b0;
                    end
                    S_DATA: begin
                        shift <= {shift[NBITS-2:0], r_write ? 1'b0 : bit_rbit};
                        if (cnt != 3'd0)
                            cnt <= cnt - 3'd1;
                    end
                    S_ACK: begin
                        if (r_write)
                            rsp_nack <= bit_rbit;
                        else
                            rsp_dout <= shift;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2cm_byte.sv
// Self-checking bench for i2cm_byte: a responsive bit-engine stand-in plus a
// request-level model of the command stream and response fields.
`timescale 1ns/1ps
module tb_i2cm_byte;
    import i2cm_defs::*;

    localparam int NBITS = 8;

    logic             clk;
    logic             rst_n;
    logic             clr_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_start;
    logic             req_stop;
    logic             req_write;
    logic             req_read;
    logic             req_ack;
    logic [NBITS-1:0] req_din;
    logic             rsp_done;
    logic [NBITS-1:0] rsp_dout;
    logic             rsp_nack;
    logic             rsp_err;
    logic             busy;
    logic [4:0]       bit_cmd;
    logic             bit_tbit;
    logic             bit_rbit;
    logic             bit_done;
    logic             bit_error;
    logic             bit_clr_n;
    logic [2:0]       fsm_state;

    i2cm_byte #(.NBITS(NBITS)) dut (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start(req_start), .req_stop(req_stop), .req_write(req_write),
        .req_read(req_read), .req_ack(req_ack), .req_din(req_din),
        .rsp_done(rsp_done), .rsp_dout(rsp_dout), .rsp_nack(rsp_nack),
        .rsp_err(rsp_err), .busy(busy),
        .bit_cmd(bit_cmd), .bit_tbit(bit_tbit), .bit_rbit(bit_rbit),
        .bit_done(bit_done), .bit_error(bit_error), .bit_clr_n(bit_clr_n),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, write, read, ack;
        logic [7:0] din;
        logic [7:0] sbyte;
        logic       sack;
        int         err_at;
        int         abort_at;
        logic [7:0] exp_dout;
        logic       exp_nack;
        logic       exp_err;
    } vec_t;

    typedef struct packed {
        logic [4:0] cmd;
        logic       tbit;
    } bc_t;

    int         n_checks;
    int         n_fail;
    bc_t        exp_q[$];
    bc_t        got_q[$];
    logic       rbit_q[$];
    logic [7:0] m_dout;
    logic       m_nack;
    logic [7:0] e_dout;
    logic       e_nack;
    logic       e_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic wr, input logic rd,
                                input logic ak, input logic [7:0] din, input logic [7:0] sb,
                                input logic sa, input int ea, input int ab,
                                input logic [7:0] xd, input logic xn, input logic xe);
        vec_t v;
        v.start = st; v.stop = sp; v.write = wr; v.read = rd; v.ack = ak;
        v.din = din; v.sbyte = sb; v.sack = sa; v.err_at = ea; v.abort_at = ab;
        v.exp_dout = xd; v.exp_nack = xn; v.exp_err = xe;
        return v;
    endfunction

    // Request-level model: the bit commands an I2C byte transfer needs, the bits the
    // slave returns, and the response fields the host should see afterwards.
    task automatic model(input vec_t v);
        logic wr, rd, stop_needed;
        wr = v.write;
        rd = v.read & ~v.write;
        exp_q.delete();
        rbit_q.delete();
        if (v.start) exp_q.push_back(bc_t'{CMD_START, 1'b1});
        if (wr) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(bc_t'{CMD_WRITE, v.din[i]});
            exp_q.push_back(bc_t'{CMD_READ, 1'b1});
            rbit_q.push_back(v.sack);
        end else if (rd) begin
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back(bc_t'{CMD_READ, 1'b1});
                rbit_q.push_back(v.sbyte[i]);
            end
            exp_q.push_back(bc_t'{CMD_WRITE, v.ack});
        end
        stop_needed = v.stop;
`ifdef I2CM_NACK_STOP_EN
        if (wr && v.sack) stop_needed = 1'b1;
`endif
        if (stop_needed) exp_q.push_back(bc_t'{CMD_STOP, 1'b1});
        e_dout = rd ? v.sbyte : m_dout;
        e_nack = wr ? v.sack : m_nack;
        e_err  = (v.err_at >= 0) && (v.err_at < exp_q.size());
    endtask

    task automatic run(input vec_t v, input bit use_table, input string tag);
        int  wc, ndone, post;
        bit  aborted;
        model(v);
        @(negedge clk);
        check({tag, ".ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_start = v.start; req_stop = v.stop; req_write = v.write;
        req_read = v.read; req_ack = v.ack; req_din = v.din;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".busy_after_accept"}, busy, 1'b1);
        check({tag, ".err_cleared"}, rsp_err, 1'b0);
        got_q.delete();
        wc = 0; ndone = 0; post = -1; aborted = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rsp_done) begin
                ndone++;
                if (ndone == 1) begin
                    post = cyc;
                    check({tag, ".dout"}, rsp_dout, use_table ? v.exp_dout : e_dout);
                    check({tag, ".nack"}, rsp_nack, use_table ? v.exp_nack : e_nack);
                    check({tag, ".err"},  rsp_err,  use_table ? v.exp_err  : e_err);
                end
            end
            if (post >= 0 && cyc >= post + 4) break;
            if (bit_cmd != CMD_NOP) begin
                wc++;
                if (v.abort_at == got_q.size() && wc == 2) begin
                    clr_n = 1'b0;
                    @(negedge clk);
                    clr_n = 1'b1;
                    check({tag, ".abort_cmd_nop"}, bit_cmd, CMD_NOP);
                    check({tag, ".abort_ready"}, req_ready, 1'b1);
                    check({tag, ".abort_no_done"}, rsp_done, 1'b0);
                    aborted = 1'b1;
                    break;
                end
                if (wc == 3) begin
                    got_q.push_back(bc_t'{bit_cmd, bit_tbit});
                    if (bit_cmd == CMD_READ) bit_rbit = (rbit_q.size() > 0) ? rbit_q.pop_front() : 1'b1;
                    if (got_q.size() - 1 == v.err_at) bit_error = 1'b1;
                    bit_done = 1'b1;
                    wc = 0;
                end
            end else begin
                wc = 0;
            end
            @(negedge clk);
            bit_done = 1'b0;
            bit_error = 1'b0;
        end
        if (aborted) begin
            ndone = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (rsp_done) ndone++;
            end
            check({tag, ".abort_done_count"}, ndone, 0);
            check({tag, ".abort_dout_kept"}, rsp_dout, m_dout);
            check({tag, ".abort_nack_kept"}, rsp_nack, m_nack);
        end else begin
            check({tag, ".done_count"}, ndone, 1);
            check({tag, ".cmd_count"}, got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                check($sformatf("%s.cmd%0d", tag, i), got_q[i].cmd, exp_q[i].cmd);
                if (exp_q[i].cmd == CMD_WRITE)
                    check($sformatf("%s.tbit%0d", tag, i), got_q[i].tbit, exp_q[i].tbit);
            end
            check({tag, ".idle_cmd"}, bit_cmd, CMD_NOP);
            check({tag, ".idle_ready"}, req_ready, 1'b1);
            m_dout = e_dout;
            m_nack = e_nack;
        end
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        n_checks = 0; n_fail = 0;
        m_dout = 8'h00; m_nack = 1'b0;
        rst_n = 1'b0; clr_n = 1'b1; req_valid = 1'b0;
        req_start = 1'b0; req_stop = 1'b0; req_write = 1'b0; req_read = 1'b0;
        req_ack = 1'b0; req_din = 8'h00;
        bit_rbit = 1'b1; bit_done = 1'b0; bit_error = 1'b0;

        tbl[0] = mk(1, 0, 1, 0, 0, 8'hA5, 8'h00, 0, -1, -1, 8'h00, 0, 0);
        tbl[1] = mk(0, 1, 0, 1, 1, 8'h00, 8'h3C, 0, -1, -1, 8'h3C, 0, 0);
        tbl[2] = mk(1, 0, 1, 0, 0, 8'h50, 8'h00, 1, -1, -1, 8'h3C, 1, 0);
        tbl[3] = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, -1, -1, 8'h3C, 1, 0);
        tbl[4] = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, -1, -1, 8'h3C, 1, 0);
        tbl[5] = mk(1, 0, 1, 0, 0, 8'hC3, 8'h00, 0, -1,  4, 8'h3C, 1, 0);
        tbl[6] = mk(1, 1, 1, 0, 0, 8'h0F, 8'h00, 0, -1, -1, 8'h3C, 0, 0);
        tbl[7] = mk(1, 1, 0, 1, 0, 8'h00, 8'h96, 0,  3, -1, 8'h96, 0, 1);
        tbl[8] = mk(0, 0, 1, 1, 0, 8'h81, 8'h00, 0, -1, -1, 8'h96, 0, 0);

        repeat (3) @(negedge clk);
        check("reset.ready", req_ready, 1'b1);
        check("reset.cmd", bit_cmd, CMD_NOP);
        check("reset.tbit", bit_tbit, 1'b1);
        check("reset.done", rsp_done, 1'b0);
        check("reset.dout", rsp_dout, 8'h00);
        check("reset.nack", rsp_nack, 1'b0);
        check("reset.err", rsp_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("clr_passthru", bit_clr_n, 1'b1);

        // A stray bit_done while idle must not start anything.
        bit_done = 1'b1; bit_rbit = 1'b0;
        @(negedge clk);
        bit_done = 1'b0; bit_rbit = 1'b1;
        @(negedge clk);
        check("stray_done.ready", req_ready, 1'b1);
        check("stray_done.cmd", bit_cmd, CMD_NOP);

        for (int i = 0; i < 9; i++) run(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        for (int i = 0; i < 30; i++) begin
            rv = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1, -1,
                    8'h00, 1'b0, 1'b0);
            run(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a read byte.
        @(negedge clk);
        req_valid = 1'b1; req_start = 1'b1; req_stop = 1'b0; req_write = 1'b0;
        req_read = 1'b1; req_ack = 1'b0; req_din = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("async.busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async.cmd", bit_cmd, CMD_NOP);
        check("async.ready", req_ready, 1'b1);
        check("async.dout", rsp_dout, 8'h00);
        check("async.nack", rsp_nack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_dout = 8'h00; m_nack = 1'b0;
        run(mk(1, 1, 1, 0, 0, 8'h6E, 8'h00, 0, -1, -1, 8'h00, 0, 0), 1'b1, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
